// File: rtl/keypad_scan_if.sv
// Signal bundle between the 4x4 keypad scanner and its matrix/consumer side.
// master is the scanner (drives strobes and key reports); slave is the matrix and consumer.
interface keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, gathers one frame of
// row samples per full rotation and debounces single-key frames into press/release events.
module keypad_scan #(
    parameter int SCAN_DIV   = 50_000,
    parameter int DIV_WIDTH  = 16,
    parameter int DEB_FRAMES = 20
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master bus
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [7:0]           DEB_TARGET = 8'(DEB_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    logic [3:0]           r_rowMeta;
    logic [3:0]           r_rowSync;
    logic [DIV_WIDTH-1:0] r_divCnt;
    logic [1:0]           r_colIdx;
    logic [3:0]           r_colOut;
    logic [4:0]           r_hitCnt;
    logic [3:0]           r_firstHit;
    logic                 r_haveHit;

    state_t               r_state;
    logic [3:0]           r_cand;
    logic [7:0]           r_deb;
    logic [7:0]           r_rel;
    logic [3:0]           r_keyCode;
    logic                 r_keyValid;
    logic                 r_keyPressed;

    logic                 w_tick;
    logic                 w_frameDone;
    logic [3:0]           w_rowLow;
    logic [2:0]           w_sampleCnt;
    logic [1:0]           w_sampleRow;
    logic [4:0]           w_frameCnt;
    logic [3:0]           w_frameFirst;
    logic                 w_frameNone;
    logic                 w_frameSingle;

    state_t               w_stateNext;
    logic [3:0]           w_candNext;
    logic [7:0]           w_debNext;
    logic [7:0]           w_relNext;
    logic [3:0]           w_keyCodeNext;
    logic                 w_keyValidNext;
    logic                 w_keyPressedNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rowMeta <= 4'b1111;
            r_rowSync <= 4'b1111;
        end else begin
            r_rowMeta <= bus.row_in;
            r_rowSync <= r_rowMeta;
        end
    end

    assign w_tick      = (r_divCnt == DIV_LAST);
    assign w_frameDone = w_tick && (r_colIdx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divCnt <= '0;
            r_colIdx <= 2'd0;
            r_colOut <= 4'b1110;
        end else if (w_tick) begin
            r_divCnt <= '0;
            r_colIdx <= r_colIdx + 2'd1;
            r_colOut <= {r_colOut[2:0], r_colOut[3]};
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    assign w_rowLow    = ~r_rowSync;
    assign w_sampleCnt = {2'b00, w_rowLow[0]} + {2'b00, w_rowLow[1]}
                       + {2'b00, w_rowLow[2]} + {2'b00, w_rowLow[3]};

    // Lowest-numbered low row wins so the first hit follows row order within a column.
    always_comb begin
        w_sampleRow = 2'd0;
        if (w_rowLow[0])      w_sampleRow = 2'd0;
        else if (w_rowLow[1]) w_sampleRow = 2'd1;
        else if (w_rowLow[2]) w_sampleRow = 2'd2;
        else if (w_rowLow[3]) w_sampleRow = 2'd3;
    end

    assign w_frameCnt    = r_hitCnt + {2'b00, w_sampleCnt};
    assign w_frameFirst  = r_haveHit ? r_firstHit : {w_sampleRow, r_colIdx};
    assign w_frameNone   = (w_frameCnt == 5'd0);
    assign w_frameSingle = (w_frameCnt == 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hitCnt   <= 5'd0;
            r_firstHit <= 4'd0;
            r_haveHit  <= 1'b0;
        end else if (w_frameDone) begin
            r_hitCnt   <= 5'd0;
            r_firstHit <= 4'd0;
            r_haveHit  <= 1'b0;
        end else if (w_tick) begin
            r_hitCnt <= w_frameCnt;
            if (!r_haveHit && (w_rowLow != 4'b0000)) begin
                r_firstHit <= {w_sampleRow, r_colIdx};
                r_haveHit  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cand       <= 4'd0;
            r_deb        <= 8'd0;
            r_rel        <= 8'd0;
            r_keyCode    <= 4'd0;
            r_keyValid   <= 1'b0;
            r_keyPressed <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cand       <= w_candNext;
            r_deb        <= w_debNext;
            r_rel        <= w_relNext;
            r_keyCode    <= w_keyCodeNext;
            r_keyValid   <= w_keyValidNext;
            r_keyPressed <= w_keyPressedNext;
        end
    end

    // Decisions happen once per completed frame; between frames everything holds.
    always_comb begin
        w_stateNext      = r_state;
        w_candNext       = r_cand;
        w_debNext        = r_deb;
        w_relNext        = r_rel;
        w_keyCodeNext    = r_keyCode;
        w_keyValidNext   = 1'b0;
        w_keyPressedNext = r_keyPressed;
        if (w_frameDone) begin
            case (r_state)
                IDLE: begin
                    if (w_frameSingle) begin
                        w_candNext  = w_frameFirst;
                        w_debNext   = 8'd1;
                        w_stateNext = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_frameSingle && (w_frameFirst == r_cand)) begin
                        w_debNext = r_deb + 8'd1;
                        if ((r_deb + 8'd1) == DEB_TARGET) begin
                            w_keyCodeNext    = r_cand;
                            w_keyValidNext   = 1'b1;
                            w_keyPressedNext = 1'b1;
                            w_stateNext      = HELD;
                        end
                    end else if (w_frameSingle) begin
                        w_candNext = w_frameFirst;
                        w_debNext  = 8'd1;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
                HELD: begin
                    if (w_frameNone) begin
                        w_relNext   = 8'd1;
                        w_stateNext = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_frameNone) begin
                        w_relNext = r_rel + 8'd1;
                        if ((r_rel + 8'd1) == DEB_TARGET) begin
                            w_keyPressedNext = 1'b0;
                            w_stateNext      = IDLE;
                        end
                    end else begin
                        w_relNext   = 8'd0;
                        w_stateNext = HELD;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    assign bus.col_out     = r_colOut;
    assign bus.key_code    = r_keyCode;
    assign bus.key_valid   = r_keyValid;
    assign bus.key_pressed = r_keyPressed;

endmodule
